shift_packer: RTL and testbench



---
 rtl/shift_packer.sv | 96 +++++++++
 tb/tb_shift_packer.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_packer.sv
// Packs a stream of IN_WIDTH-bit lanes into OUT_WIDTH-bit words in MSB- or LSB-first order.
// Both sides are valid/ready; flush emits the partial word zero-padded into full-word positions.
module shift_packer #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 32,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic                                      clock,
    input  logic                                      clear_n,
    input  logic                                      in_valid,
    input  logic [IN_WIDTH-1:0]                       in_data,
    output logic                                      in_ready,
    input  logic                                      flush,
    output logic [$clog2(OUT_WIDTH/IN_WIDTH)-1:0]     fill,
    output logic                                      out_valid,
    output logic [OUT_WIDTH-1:0]                      out_data,
    output logic [$clog2(OUT_WIDTH/IN_WIDTH+1)-1:0]   out_count,
    output logic                                      out_last,
    input  logic                                      out_ready
);

    localparam int unsigned K  = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned FW = $clog2(K);
    localparam int unsigned CW = $clog2(K + 1);

    logic [OUT_WIDTH-1:0] packQ;
    logic [OUT_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0] packNext;
    logic [OUT_WIDTH-1:0] flushWord;
    logic [CW-1:0]        laneCount;
    logic [31:0]          padShift;
    logic                 outFree;
    logic                 lastLane;
    logic                 accept;
    logic                 complete;
    logic                 doFlush;

    always_comb begin
        outFree  = !out_valid || out_ready;
        lastLane = (fill == FW'(K - 1));
        // Only the completing lane needs room in the output register.
        in_ready = clear_n && (!lastLane || outFree);
        accept   = in_valid && in_ready;

        if (LSB_FIRST) begin
            shifted = {in_data, packQ[OUT_WIDTH-1:IN_WIDTH]};
        end else begin
            shifted = {packQ[OUT_WIDTH-IN_WIDTH-1:0], in_data};
        end

        packNext  = accept ? shifted : packQ;
        laneCount = CW'(fill) + CW'(accept);
        complete  = accept && lastLane;
        doFlush   = flush && outFree && !complete && (laneCount != '0);

        // Shifting out the empty lane slots also drops stale lanes from the previous word.
        padShift  = IN_WIDTH * (K - 32'(laneCount));
        if (LSB_FIRST) begin
            flushWord = packNext >> padShift;
        end else begin
            flushWord = packNext << padShift;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            packQ     <= '0;
            fill      <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (complete) begin
            packQ     <= shifted;
            fill      <= '0;
            out_data  <= shifted;
            out_count <= CW'(K);
            out_last  <= 1'b0;
            out_valid <= 1'b1;
        end else if (doFlush) begin
            packQ     <= '0;
            fill      <= '0;
            out_data  <= flushWord;
            out_count <= laneCount;
            out_last  <= 1'b1;
            out_valid <= 1'b1;
        end else begin
            packQ <= packNext;
            fill  <= fill + FW'(accept);
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_packer.sv
// Bench for shift_packer: MSB-first 8/32, LSB-first 8/32 and MSB-first 4/16 instances,
// with expected words queued at stimulus time and popped as each word is consumed.
module tb_shift_packer;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  count;
        logic        isLast;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic clear_n;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t mQ[$];
    exp_t lQ[$];
    exp_t sQ[$];
    exp_t e;

    logic        mInValid, mInReady, mFlush, mOutValid, mOutLast, mOutReady;
    logic [7:0]  mInData;
    logic [1:0]  mFill;
    logic [31:0] mOutData;
    logic [2:0]  mOutCount;

    logic        lInValid, lInReady, lFlush, lOutValid, lOutLast, lOutReady;
    logic [7:0]  lInData;
    logic [1:0]  lFill;
    logic [31:0] lOutData;
    logic [2:0]  lOutCount;

    logic        sInValid, sInReady, sFlush, sOutValid, sOutLast, sOutReady;
    logic [3:0]  sInData;
    logic [1:0]  sFill;
    logic [15:0] sOutData;
    logic [2:0]  sOutCount;

    shift_packer #(.IN_WIDTH(8), .OUT_WIDTH(32), .LSB_FIRST(1'b0)) dutMsb (
        .clock(clock), .clear_n(clear_n), .in_valid(mInValid), .in_data(mInData),
        .in_ready(mInReady), .flush(mFlush), .fill(mFill), .out_valid(mOutValid),
        .out_data(mOutData), .out_count(mOutCount), .out_last(mOutLast), .out_ready(mOutReady));

    shift_packer #(.IN_WIDTH(8), .OUT_WIDTH(32), .LSB_FIRST(1'b1)) dutLsb (
        .clock(clock), .clear_n(clear_n), .in_valid(lInValid), .in_data(lInData),
        .in_ready(lInReady), .flush(lFlush), .fill(lFill), .out_valid(lOutValid),
        .out_data(lOutData), .out_count(lOutCount), .out_last(lOutLast), .out_ready(lOutReady));

    shift_packer #(.IN_WIDTH(4), .OUT_WIDTH(16), .LSB_FIRST(1'b0)) dutSmall (
        .clock(clock), .clear_n(clear_n), .in_valid(sInValid), .in_data(sInData),
        .in_ready(sInReady), .flush(sFlush), .fill(sFill), .out_valid(sOutValid),
        .out_data(sOutData), .out_count(sOutCount), .out_last(sOutLast), .out_ready(sOutReady));

    function automatic exp_t mk(input logic [31:0] d, input logic [2:0] c, input logic l);
        exp_t r;
        r.data = d;
        r.count = c;
        r.isLast = l;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        mInValid = 0; mInData = '0; mFlush = 0; mOutReady = 1;
        lInValid = 0; lInData = '0; lFlush = 0; lOutReady = 1;
        sInValid = 0; sInData = '0; sFlush = 0; sOutReady = 1;
        tick();
        tick();
        compared++;
        if ({mInReady, mFill, mOutValid, mOutData, mOutCount, mOutLast} !== '0) begin
            mismatched++;
            $display("FAIL reset_msb: rdy=%b fill=%0d v=%b data=%h cnt=%0d last=%b, want all 0",
                     mInReady, mFill, mOutValid, mOutData, mOutCount, mOutLast);
        end
        compared++;
        if ({lInReady, lFill, lOutValid, lOutData, lOutCount, lOutLast} !== '0) begin
            mismatched++;
            $display("FAIL reset_lsb: rdy=%b fill=%0d v=%b data=%h cnt=%0d last=%b, want all 0",
                     lInReady, lFill, lOutValid, lOutData, lOutCount, lOutLast);
        end
        compared++;
        if ({sInReady, sFill, sOutValid, sOutData, sOutCount, sOutLast} !== '0) begin
            mismatched++;
            $display("FAIL reset_small: rdy=%b fill=%0d v=%b data=%h cnt=%0d last=%b, want all 0",
                     sInReady, sFill, sOutValid, sOutData, sOutCount, sOutLast);
        end
        clear_n = 1'b1;
        #1;
        compared++;
        if ({mInReady, lInReady, sInReady} !== 3'b111) begin
            mismatched++;
            $display("FAIL reset_release_ready: got %b want 111", {mInReady, lInReady, sInReady});
        end
        tick();
    endtask

    task automatic test_lane_order();
        logic [7:0] lanes[4];
        lanes = '{8'h44, 8'h77, 8'h11, 8'h22};
        mQ.push_back(mk(32'h44771122, 3'd4, 1'b0));
        lQ.push_back(mk(32'h22117744, 3'd4, 1'b0));
        for (int i = 0; i < 4; i++) begin
            mInValid = 1; mInData = lanes[i];
            lInValid = 1; lInData = lanes[i];
            #1;
            compared++;
            if (mInReady !== 1'b1 || lInReady !== 1'b1) begin
                mismatched++;
                $display("FAIL order_in_ready lane %0d: got m=%b l=%b want 1", i, mInReady, lInReady);
            end
            tick();
            compared++;
            if (mOutValid !== 1'(i == 3) || lOutValid !== 1'(i == 3)) begin
                mismatched++;
                $display("FAIL order_valid_timing lane %0d: got m=%b l=%b want %b",
                         i, mOutValid, lOutValid, i == 3);
            end
        end
        mInValid = 0; lInValid = 0;
        #1;
        if (mOutValid && mOutReady) begin
            compared++;
            if (mQ.size() == 0) begin
                mismatched++;
                $display("FAIL order_msb_word: got unexpected %h, want none", mOutData);
            end else begin
                e = mQ.pop_front();
                if ({mOutData, mOutCount, mOutLast} !== {e.data, e.count, e.isLast}) begin
                    mismatched++;
                    $display("FAIL order_msb_word: got %h/%0d/%b want %h/%0d/%b",
                             mOutData, mOutCount, mOutLast, e.data, e.count, e.isLast);
                end
            end
        end
        if (lOutValid && lOutReady) begin
            compared++;
            if (lQ.size() == 0) begin
                mismatched++;
                $display("FAIL order_lsb_word: got unexpected %h, want none", lOutData);
            end else begin
                e = lQ.pop_front();
                if ({lOutData, lOutCount, lOutLast} !== {e.data, e.count, e.isLast}) begin
                    mismatched++;
                    $display("FAIL order_lsb_word: got %h/%0d/%b want %h/%0d/%b",
                             lOutData, lOutCount, lOutLast, e.data, e.count, e.isLast);
                end
            end
        end
        tick();
        compared++;
        if (mOutValid !== 1'b0 || lOutValid !== 1'b0 || mQ.size() != 0 || lQ.size() != 0) begin
            mismatched++;
            $display("FAIL order_drain: got m=%b l=%b pending=%0d/%0d want 0 0 0/0",
                     mOutValid, lOutValid, mQ.size(), lQ.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] lanes[8];
        lanes = '{8'h44, 8'h77, 8'h11, 8'h22, 8'h55, 8'h66, 8'h77, 8'h88};
        mOutReady = 1;
        mQ.push_back(mk(32'h44771122, 3'd4, 1'b0));
        mQ.push_back(mk(32'h55667788, 3'd4, 1'b0));
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                mInValid = 1; mInData = lanes[i];
            end else begin
                mInValid = 0;
            end
            #1;
            if (i < 8) begin
                compared++;
                if (mInReady !== 1'b1) begin
                    mismatched++;
                    $display("FAIL b2b_no_stall lane %0d: got in_ready=%b want 1", i, mInReady);
                end
            end
            if (mOutValid && mOutReady) begin
                compared++;
                if (mQ.size() == 0) begin
                    mismatched++;
                    $display("FAIL b2b_word: got unexpected %h, want none", mOutData);
                end else begin
                    e = mQ.pop_front();
                    if ({mOutData, mOutCount, mOutLast} !== {e.data, e.count, e.isLast}) begin
                        mismatched++;
                        $display("FAIL b2b_word: got %h/%0d/%b want %h/%0d/%b",
                                 mOutData, mOutCount, mOutLast, e.data, e.count, e.isLast);
                    end
                end
            end
            tick();
        end
        compared++;
        if (mOutValid !== 1'b0 || mQ.size() != 0) begin
            mismatched++;
            $display("FAIL b2b_drain: got valid=%b pending=%0d want 0 0", mOutValid, mQ.size());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] lanes[8];
        lanes = '{8'h44, 8'h77, 8'h11, 8'h22, 8'h55, 8'h66, 8'h77, 8'h88};
        mOutReady = 0;
        mQ.push_back(mk(32'h44771122, 3'd4, 1'b0));
        mQ.push_back(mk(32'h55667788, 3'd4, 1'b0));
        for (int i = 0; i < 7; i++) begin
            mInValid = 1; mInData = lanes[i];
            #1;
            compared++;
            if (mInReady !== 1'b1) begin
                mismatched++;
                $display("FAIL bp_accept lane %0d: got in_ready=%b want 1", i, mInReady);
            end
            tick();
        end
        mInData = lanes[7];
        #1;
        for (int c = 0; c < 3; c++) begin
            compared++;
            if (mInReady !== 1'b0 || mFill !== 2'd3 || mOutValid !== 1'b1 || mOutData !== 32'h44771122) begin
                mismatched++;
                $display("FAIL bp_stall cycle %0d: got rdy=%b fill=%0d v=%b data=%h want 0 3 1 44771122",
                         c, mInReady, mFill, mOutValid, mOutData);
            end
            tick();
        end
        mOutReady = 1;
        #1;
        compared++;
        if (mInReady !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_release_ready: got %b want 1", mInReady);
        end
        for (int c = 0; c < 2; c++) begin
            if (mOutValid && mOutReady) begin
                compared++;
                if (mQ.size() == 0) begin
                    mismatched++;
                    $display("FAIL bp_word: got unexpected %h, want none", mOutData);
                end else begin
                    e = mQ.pop_front();
                    if ({mOutData, mOutCount, mOutLast} !== {e.data, e.count, e.isLast}) begin
                        mismatched++;
                        $display("FAIL bp_word: got %h/%0d/%b want %h/%0d/%b",
                                 mOutData, mOutCount, mOutLast, e.data, e.count, e.isLast);
                    end
                end
            end
            tick();
            mInValid = 0;
            #1;
        end
        compared++;
        if (mOutValid !== 1'b0 || mQ.size() != 0) begin
            mismatched++;
            $display("FAIL bp_drain: got valid=%b pending=%0d want 0 0", mOutValid, mQ.size());
        end
    endtask

    task automatic test_flush_partial();
        logic [7:0] lanes[3];
        lanes = '{8'h44, 8'h77, 8'h11};
        mQ.push_back(mk(32'h44771100, 3'd3, 1'b1));
        lQ.push_back(mk(32'h00117744, 3'd3, 1'b1));
        for (int i = 0; i < 3; i++) begin
            mInValid = 1; mInData = lanes[i];
            lInValid = 1; lInData = lanes[i];
            tick();
        end
        mInValid = 0; lInValid = 0;
        mFlush = 1; lFlush = 1;
        #1;
        compared++;
        if (mFill !== 2'd3 || lFill !== 2'd3 || mOutValid !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_pre_fill: got m=%0d l=%0d v=%b want 3 3 0", mFill, lFill, mOutValid);
        end
        tick();
        mFlush = 0; lFlush = 0;
        #1;
        compared++;
        if (mFill !== 2'd0 || lFill !== 2'd0) begin
            mismatched++;
            $display("FAIL flush_fill_cleared: got m=%0d l=%0d want 0 0", mFill, lFill);
        end
        compared++;
        if (mQ.size() == 0 || mOutValid !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_msb_word: got valid=%b want a flushed word", mOutValid);
        end else begin
            e = mQ.pop_front();
            if ({mOutData, mOutCount, mOutLast} !== {e.data, e.count, e.isLast}) begin
                mismatched++;
                $display("FAIL flush_msb_word: got %h/%0d/%b want %h/%0d/%b",
                         mOutData, mOutCount, mOutLast, e.data, e.count, e.isLast);
            end
        end
        compared++;
        if (lQ.size() == 0 || lOutValid !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_lsb_word: got valid=%b want a flushed word", lOutValid);
        end else begin
            e = lQ.pop_front();
            if ({lOutData, lOutCount, lOutLast} !== {e.data, e.count, e.isLast}) begin
                mismatched++;
                $display("FAIL flush_lsb_word: got %h/%0d/%b want %h/%0d/%b",
                         lOutData, lOutCount, lOutLast, e.data, e.count, e.isLast);
            end
        end
        tick();
        compared++;
        if (mOutValid !== 1'b0 || lOutValid !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_drain: got m=%b l=%b want 0 0", mOutValid, lOutValid);
        end
    endtask

    task automatic test_flush_blocked();
        logic [7:0] lanes[5];
        lanes = '{8'h44, 8'h77, 8'h11, 8'h22, 8'h99};
        // Flush on an empty packer produces nothing.
        mFlush = 1;
        tick();
        tick();
        compared++;
        if (mOutValid !== 1'b0 || mFill !== 2'd0) begin
            mismatched++;
            $display("FAIL flush_empty_noop: got valid=%b fill=%0d want 0 0", mOutValid, mFill);
        end
        mFlush = 0;
        mOutReady = 0;
        mQ.push_back(mk(32'h44771122, 3'd4, 1'b0));
        mQ.push_back(mk(32'h99000000, 3'd1, 1'b1));
        for (int i = 0; i < 5; i++) begin
            mInValid = 1; mInData = lanes[i];
            tick();
        end
        mInValid = 0;
        mFlush = 1;
        for (int c = 0; c < 2; c++) begin
            tick();
            compared++;
            if (mFill !== 2'd1 || mOutLast !== 1'b0 || mOutData !== 32'h44771122) begin
                mismatched++;
                $display("FAIL flush_blocked cycle %0d: got fill=%0d last=%b data=%h want 1 0 44771122",
                         c, mFill, mOutLast, mOutData);
            end
        end
        mOutReady = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            if (mOutValid && mOutReady) begin
                compared++;
                if (mQ.size() == 0) begin
                    mismatched++;
                    $display("FAIL flush_blocked_word: got unexpected %h, want none", mOutData);
                end else begin
                    e = mQ.pop_front();
                    if ({mOutData, mOutCount, mOutLast} !== {e.data, e.count, e.isLast}) begin
                        mismatched++;
                        $display("FAIL flush_blocked_word: got %h/%0d/%b want %h/%0d/%b",
                                 mOutData, mOutCount, mOutLast, e.data, e.count, e.isLast);
                    end
                end
            end
            tick();
            mFlush = 0;
        end
        compared++;
        if (mOutValid !== 1'b0 || mQ.size() != 0) begin
            mismatched++;
            $display("FAIL flush_blocked_drain: got valid=%b pending=%0d want 0 0", mOutValid, mQ.size());
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] lanes[4];
        lanes = '{8'h44, 8'h77, 8'h11, 8'h22};
        mOutReady = 1;
        mQ.push_back(mk(32'h44771122, 3'd4, 1'b0));
        for (int i = 0; i < 4; i++) begin
            mInValid = 1; mInData = lanes[i];
            mFlush = (i == 3);
            tick();
        end
        mInValid = 0;
        #1;
        compared++;
        if (mQ.size() == 0 || mOutValid !== 1'b1 || mFill !== 2'd0) begin
            mismatched++;
            $display("FAIL simul_full_word: got valid=%b fill=%0d want 1 0", mOutValid, mFill);
        end else begin
            e = mQ.pop_front();
            if ({mOutData, mOutCount, mOutLast} !== {e.data, e.count, e.isLast}) begin
                mismatched++;
                $display("FAIL simul_full_word: got %h/%0d/%b want %h/%0d/%b",
                         mOutData, mOutCount, mOutLast, e.data, e.count, e.isLast);
            end
        end
        tick();
        compared++;
        if (mOutValid !== 1'b0) begin
            mismatched++;
            $display("FAIL simul_flush_after_full: got valid=%b want 0", mOutValid);
        end
        mFlush = 0;
        mQ.push_back(mk(32'h44770000, 3'd2, 1'b1));
        for (int i = 0; i < 2; i++) begin
            mInValid = 1; mInData = lanes[i];
            mFlush = (i == 1);
            tick();
        end
        mInValid = 0; mFlush = 0;
        #1;
        compared++;
        if (mQ.size() == 0 || mOutValid !== 1'b1) begin
            mismatched++;
            $display("FAIL simul_two_lane_flush: got valid=%b want 1", mOutValid);
        end else begin
            e = mQ.pop_front();
            if ({mOutData, mOutCount, mOutLast} !== {e.data, e.count, e.isLast}) begin
                mismatched++;
                $display("FAIL simul_two_lane_flush: got %h/%0d/%b want %h/%0d/%b",
                         mOutData, mOutCount, mOutLast, e.data, e.count, e.isLast);
            end
        end
        tick();
    endtask

    task automatic test_reset_midword();
        logic [3:0] nib[4];
        nib = '{4'hA, 4'hB, 4'hC, 4'hD};
        // Hold a full word plus one lane in the wide packer while the narrow one is mid-word.
        mOutReady = 0; sOutReady = 1;
        for (int i = 0; i < 5; i++) begin
            mInValid = 1; mInData = 8'(8'h30 + i);
            sInValid = (i < 2); sInData = 4'(i + 3);
            tick();
        end
        mInValid = 0; sInValid = 0;
        clear_n = 1'b0;
        tick();
        compared++;
        if ({sInReady, sFill, sOutValid, sOutData, sOutCount, sOutLast} !== '0) begin
            mismatched++;
            $display("FAIL midreset_small: rdy=%b fill=%0d v=%b data=%h cnt=%0d last=%b want all 0",
                     sInReady, sFill, sOutValid, sOutData, sOutCount, sOutLast);
        end
        compared++;
        if ({mInReady, mFill, mOutValid, mOutData} !== '0) begin
            mismatched++;
            $display("FAIL midreset_msb: rdy=%b fill=%0d v=%b data=%h want all 0",
                     mInReady, mFill, mOutValid, mOutData);
        end
        clear_n = 1'b1;
        mOutReady = 1;
        sQ.push_back(mk(32'h0000ABCD, 3'd4, 1'b0));
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                sInValid = 1; sInData = nib[i];
            end else begin
                sInValid = 0;
            end
            #1;
            if (sOutValid && sOutReady) begin
                compared++;
                if (sQ.size() == 0) begin
                    mismatched++;
                    $display("FAIL midreset_word: got unexpected %h, want none", sOutData);
                end else begin
                    e = sQ.pop_front();
                    if ({16'h0, sOutData, sOutCount, sOutLast} !== {e.data, e.count, e.isLast}) begin
                        mismatched++;
                        $display("FAIL midreset_word: got %h/%0d/%b want %h/%0d/%b",
                                 sOutData, sOutCount, sOutLast, e.data, e.count, e.isLast);
                    end
                end
            end
            tick();
        end
        compared++;
        if (sOutValid !== 1'b0 || sQ.size() != 0) begin
            mismatched++;
            $display("FAIL midreset_drain: got valid=%b pending=%0d want 0 0", sOutValid, sQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_lane_order();
        test_back_to_back();
        test_backpressure();
        test_flush_partial();
        test_flush_blocked();
        test_simultaneous();
        test_reset_midword();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
